// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream, as seen by fifo_stream_reader.
// master: the reader side; slave: the FIFO/downstream side (testbench).
interface fifo_stream_reader_if #(
    parameter int unsigned WIDTH = 24
);
    logic             fifo_rd;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (
        output fifo_rd, m_data, m_valid, m_last,
        input  fifo_empty, fifo_dout, m_ready
    );

    modport slave (
        input  fifo_rd, m_data, m_valid, m_last,
        output fifo_empty, fifo_dout, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream.
// A 2-entry skid buffer hides the one-cycle FIFO read latency so a word can
// be delivered every cycle; the stream is framed into PKT_LEN-word packets.
module fifo_stream_reader #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned PKT_LEN = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [CNT_W-1:0]     word_cnt,
    fifo_stream_reader_if.master bus_io
);
    localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatW-1:0] BeatLast = BeatW'(PKT_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic             pending_q;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pop;
    logic [2:0] occ_sum;
    logic       tail_is_one;

    assign pop     = bus_io.m_valid & bus_io.m_ready;
    // Occupancy after this cycle's capture and pop; pop implies occ_q >= 1.
    assign occ_sum = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};

    // Read only if the word arriving next cycle is guaranteed a free slot.
    assign bus_io.fifo_rd = rst & en & ~bus_io.fifo_empty & (occ_sum <= 3'd1);

    assign bus_io.m_valid = (occ_q != 2'd0);
    assign bus_io.m_data  = buf0_q;
    assign bus_io.m_last  = (beat_q == BeatLast) & bus_io.m_valid;
    assign word_cnt       = cnt_q;

    // Slot written by a capture, evaluated after a same-cycle pop shifts the head.
    assign tail_is_one = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);

    // Next-state: buffer shift/capture, occupancy, beat and word counters.
    always_comb begin
        occ_d  = occ_sum[1:0];
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        beat_d = beat_q;
        cnt_d  = cnt_q;

        if (pop) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q + CNT_W'(1);
            beat_d = (beat_q == BeatLast) ? '0 : beat_q + BeatW'(1);
        end

        if (pending_q) begin
            if (tail_is_one) begin
                buf1_d = bus_io.fifo_dout;
            end else begin
                buf0_d = bus_io.fifo_dout;
            end
        end
    end

    // State registers; reset drops any in-flight and buffered words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q     <= 2'd0;
            pending_q <= 1'b0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
        end else begin
            occ_q     <= occ_d;
            pending_q <= bus_io.fifo_rd;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based FIFO model feeds
// the DUT and a scoreboard checks order, framing, counting and flow control.
module tb_fifo_stream_reader;
    localparam int unsigned WIDTH   = 24;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [CNT_W-1:0] word_cnt;

    fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_stream_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .word_cnt (word_cnt),
        .bus_io   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               reads = 0;
    int               pops  = 0;
    int               lasts = 0;
    int               cyc   = 0;
    int               val_cnt = 0;
    int               rd_last_cyc = 0;
    int               val_last_cyc = 0;
    logic [WIDTH-1:0] last_pop_data = '0;
    logic             last_valid_s = 1'b0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample at negedge, model the FIFO's registered read after posedge.
    task automatic step();
        logic             rd_s;
        logic             pop_s;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        rd_s  = bus.fifo_rd;
        pop_s = bus.m_valid & bus.m_ready;
        check_eq("rd_while_empty", rd_s & bus.fifo_empty, 0);
        check_eq("rd_in_reset", rd_s & ~rst, 0);
        if (stall_prev) begin
            check_eq("stall_valid", bus.m_valid, 1);
            check_eq("stall_data", bus.m_data, stall_data);
        end
        check_eq("m_last", bus.m_last,
                 bus.m_valid && ((pops % int'(PKT_LEN)) == int'(PKT_LEN) - 1));
        if (pop_s) begin
            check_eq("sb_has_word", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("m_data", bus.m_data, w);
            end
            check_eq("word_cnt", word_cnt, pops);
            pops++;
            if (bus.m_last) lasts++;
            val_last_cyc  = cyc;
            last_pop_data = bus.m_data;
        end
        if (bus.m_valid) val_cnt++;
        if (rd_s) rd_last_cyc = cyc;
        stall_prev   = bus.m_valid & ~bus.m_ready & rst;
        stall_data   = bus.m_data;
        last_valid_s = bus.m_valid;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            bus.fifo_dout = w;
            exp_q.push_back(w);
            reads++;
            bus.fifo_empty = (fifo_q.size() == 0);
        end
        check_eq("inflight_le2", (reads - pops) <= 2, 1);
        cyc++;
    endtask

    // Asynchronous reset between clock edges, with the FIFO model reset alongside.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        bus.fifo_dout  = '0;
        bus.fifo_empty = 1'b1;
        reads      = 0;
        pops       = 0;
        stall_prev = 1'b0;
        #1;
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_m_last", bus.m_last, 0);
        check_eq("rst_m_data", bus.m_data, 0);
        check_eq("rst_fifo_rd", bus.fifo_rd, 0);
        check_eq("rst_word_cnt", word_cnt, 0);
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int p0;
        int l0;
        int v0;
        int outst;
        int guard;
        int written;

        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.m_ready    = 1'b0;

        // Reset then idle
        #2;
        check_eq("init_m_valid", bus.m_valid, 0);
        check_eq("init_fifo_rd", bus.fifo_rd, 0);
        check_eq("init_word_cnt", word_cnt, 0);
        check_eq("init_m_data", bus.m_data, 0);
        repeat (2) step();
        rst = 1'b1;
        en  = 1'b1;
        r0  = reads;
        repeat (5) step();
        check_eq("idle_reads", reads - r0, 0);

        // Single word: read at N, valid at N+2 for one cycle
        bus.m_ready = 1'b1;
        push_word(24'hABCDEF);
        r0 = reads;
        v0 = val_cnt;
        repeat (6) step();
        check_eq("single_reads", reads - r0, 1);
        check_eq("single_valids", val_cnt - v0, 1);
        check_eq("single_latency", val_last_cyc - rd_last_cyc, 2);
        check_eq("single_data", last_pop_data, 24'hABCDEF);
        check_eq("single_cnt", word_cnt, 1);

        // Streaming 32 words from a fresh reset
        do_reset();
        for (int i = 1; i <= 32; i++) push_word(WIDTH'(i));
        p0 = pops;
        l0 = lasts;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!last_valid_s && guard < 10);
        check_eq("stream_start", last_valid_s, 1);
        repeat (31) step();
        check_eq("stream_pops", pops - p0, 32);
        check_eq("stream_lasts", lasts - l0, 8);
        check_eq("stream_cnt", word_cnt, 32);

        // Backpressure: only two words read ahead while stalled
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(WIDTH'(32'h100 + i));
        r0 = reads;
        repeat (10) step();
        check_eq("bp_reads", reads - r0, 2);
        check_eq("bp_valid", bus.m_valid, 1);
        check_eq("bp_head", bus.m_data, 24'h000101);
        bus.m_ready = 1'b1;
        p0 = pops;
        repeat (8) step();
        check_eq("bp_drain", pops - p0, 8);

        // Random ready and FIFO writes
        p0      = pops;
        written = 0;
        guard   = 0;
        while ((pops - p0) < 1000 && guard < 20000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if (written < 1000 && $urandom_range(0, 3) != 0) begin
                push_word(WIDTH'($urandom));
                written++;
            end
            step();
            guard++;
        end
        check_eq("rand_pops", pops - p0, 1000);
        check_eq("rand_sb_empty", exp_q.size(), 0);
        check_eq("rand_fifo_empty", fifo_q.size(), 0);

        // en dropped mid-stream: only in-flight words still come out
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(WIDTH'(32'h500 + i));
        repeat (5) step();
        en    = 1'b0;
        outst = reads - pops;
        p0    = pops;
        r0    = reads;
        repeat (6) step();
        check_eq("en_outst_le2", outst <= 2, 1);
        check_eq("en_drained", pops - p0, outst);
        check_eq("en_no_reads", reads - r0, 0);
        check_eq("en_valid_off", bus.m_valid, 0);

        // Reset mid-stream, then packet framing restarts at beat 0
        en = 1'b1;
        repeat (3) step();
        do_reset();
        for (int i = 0; i < 6; i++) push_word(WIDTH'(32'h700 + i));
        l0    = lasts;
        guard = 0;
        while (pops < 6 && guard < 30) begin
            step();
            guard++;
        end
        check_eq("post_rst_pops", pops, 6);
        check_eq("post_rst_lasts", lasts - l0, 1);
        check_eq("post_rst_cnt", word_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drains the read port of the team's synchronous FIFO (rd/dout/empty; dout registered, valid one cycle after an accepted rd) and presents the words as a valid/ready stream. A 2-entry output buffer absorbs the FIFO's read latency, giving one word per cycle under continuous m_ready. The block also frames the stream into fixed-length packets with m_last and keeps a running word count.

Parameters:
WIDTH, 24, data word width; must equal the FIFO WIDTH.
PKT_LEN, 16, words per packet; m_last marks word PKT_LEN-1 of each packet; PKT_LEN>=1.
CNT_W, 32, width of the delivered-word counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
en  input  1  read enable; 0 stops issuing new FIFO reads
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  WIDTH  FIFO registered read data
fifo_rd  output  1  FIFO read strobe
m_data  output  WIDTH  stream data
m_valid  output  1  stream data valid
m_last  output  1  last word of the current packet
m_ready  input  1  downstream accept
word_cnt  output  CNT_W  words delivered since reset

Behaviour:
- Reset (rst=0, async assert, sync release): buffer occupancy occ=0, pending=0, beat counter=0, word_cnt=0. m_valid=0, m_last=0, m_data=0. fifo_rd=0 combinationally while rst=0.
- pop = m_valid & m_ready.
- fifo_rd = en & ~fifo_empty & (occ + pending - pop <= 1). This path is combinational from m_ready; that path is intended. fifo_rd is never asserted while fifo_empty=1, so the FIFO's empty-read bypass path is never exercised.
- pending register: set to fifo_rd each cycle. It marks that fifo_dout carries a fresh word in the current cycle.
- Capture: when pending=1, fifo_dout is written into the buffer tail in that cycle.
- Buffer: 2-entry FIFO, head drives m_data. Simultaneous capture and pop are allowed in the same cycle, including when occ=2.
- occ_next = occ + pending - pop. occ never exceeds 2; a bench assertion checks this.
- m_valid = (occ != 0), registered.
- Latency: fifo_rd in cycle N -> word captured in N+1 -> m_valid with that word in N+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, fifo_rd and pop are both 1 every cycle in steady state.
- Backpressure: with m_ready=0, at most 2 words are read beyond the last pop. After that fifo_rd stays 0 until a pop.
- m_data and m_valid hold stable while m_valid=1 and m_ready=0. Stream order equals FIFO order.
- Beat counter: 0..PKT_LEN-1, increments on pop, wraps to 0 on the pop of beat PKT_LEN-1. m_last = (beat == PKT_LEN-1) & m_valid. With PKT_LEN=1, m_last = m_valid.
- word_cnt increments on each pop and wraps modulo 2^CNT_W.
- en: deasserting en stops new fifo_rd only. Pending and buffered words are still delivered. The beat counter is not reset by en.
- Reset mid-operation: pending and buffered words are discarded and the beat counter restarts at 0. The FIFO must be reset in the same cycle; otherwise one word read but not captured is lost.

Test Plan:
- Reset then idle: rst=0 with fifo_empty=1 -> m_valid=0, fifo_rd=0, word_cnt=0; after rst=1 held 5 cycles with fifo_empty=1, fifo_rd stays 0.
- Single word: FIFO holds 0xABCDEF, m_ready=1, en=1 -> fifo_rd high for exactly 1 cycle (N); m_valid with m_data=0xABCDEF in N+2 for 1 cycle; word_cnt=1.
- Streaming: FIFO preloaded with 0x000001..0x000020, m_ready=1 -> 32 consecutive valid cycles carrying values in order; with PKT_LEN=4, m_last on words 4, 8, ..., 32; word_cnt=32.
- Backpressure: 8 words queued, m_ready=0 -> exactly 2 fifo_rd pulses, occ=2, m_data stable at word 1. Then m_ready=1 -> words 1..8 delivered in order with no gap after the first.
- Random m_ready (50%) over 1000 words with random FIFO writes -> scoreboard matches order, no loss or duplication, occ<=2 always, and fifo_rd never high while fifo_empty=1.
- en and async reset: en dropped mid-stream -> at most 2 further words delivered, then m_valid=0. rst asserted mid-beat with the FIFO reset in the same cycle -> outputs clear immediately; after release, the first delivered word has m_last only at beat PKT_LEN.
